// File: rtl/seg_scan_pkg.sv
// Shared constants, FSM encoding and digit-mask helper for the 4-digit
// 7-segment scan controller.
package seg_scan_pkg;

  localparam int NDIG = 4;
  localparam int IDXW = 2;
  localparam logic [NDIG-1:0] DIGIT_OFF = 4'b1111;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  // Active-low enable mask with only digit idx driven.
  function automatic logic [NDIG-1:0] onehot_n(input logic [IDXW-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer for the digit scanner: counts REFRESH_DIV cycles per slot and
// steps the digit index 0..3, flagging the end of blanking and of the slot.
module scan_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int CW          = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [CW-1:0]   cnt,
  output logic [IDXW-1:0] idx,
  output logic            slot_end,
  output logic            blank_end
);

  logic [CW-1:0]   r_cnt;
  logic [IDXW-1:0] r_idx;

  assign slot_end  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign blank_end = (r_cnt == CW'(BLANK_CYC - 1));
  assign cnt       = r_cnt;
  assign idx       = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + IDXW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of four hex digits onto one shared decoder.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NDIG-1:0]    value,
  input  logic [NDIG-1:0]      dig_en,
  output logic [3:0]           hex_out,
  output logic [NDIG-1:0]      dign,
  output logic                 frame_done
);

  localparam int CW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);

  logic [CW-1:0]     w_cnt;
  logic [IDXW-1:0]   w_idx;
  logic              w_slot_end;
  logic              w_blank_end;
  logic              w_snap;
  logic              w_suppress;
  logic [4*NDIG-1:0] w_shadow_next;
  logic [3:0]        w_hex_next;
  logic [NDIG-1:0]   w_dign_next;
  logic              w_fd_next;
  scan_state_e       w_state_next;

  scan_state_e       r_state;
  logic [4*NDIG-1:0] r_shadow;
  logic [3:0]        r_hex;
  logic [NDIG-1:0]   r_dign;
  logic              r_frame_done;

  scan_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .CW          (CW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (w_cnt),
    .idx       (w_idx),
    .slot_end  (w_slot_end),
    .blank_end (w_blank_end)
  );

  // Bypass the snapshot so a 1-cycle blank still sees the new frame value.
  assign w_snap        = (w_idx == '0) && (w_cnt == '0);
  assign w_shadow_next = w_snap ? value : r_shadow;

`ifdef SEG_SCAN_LZB_EN
  logic [NDIG-1:0] w_zero_from;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_zero_from
    assign w_zero_from[gi] = (w_shadow_next[4*NDIG-1:4*gi] == '0);
  end

  assign w_suppress = (w_idx != '0) && w_zero_from[w_idx];
`else
  assign w_suppress = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_hex_next   = r_hex;
    w_dign_next  = DIGIT_OFF;
    w_fd_next    = (w_idx == IDXW'(NDIG - 1)) && (w_cnt == CW'(REFRESH_DIV - 2));
    case (r_state)
      S_BLANK: begin
        w_hex_next = w_shadow_next[{w_idx, 2'b00} +: 4];
        if (w_blank_end) begin
          w_state_next = S_SHOW;
          if (dig_en[w_idx] && !w_suppress) w_dign_next = onehot_n(w_idx);
        end
      end
      S_SHOW: begin
        if (w_slot_end) begin
          w_state_next = S_BLANK;
        end else if (dig_en[w_idx] && !w_suppress) begin
          w_dign_next = onehot_n(w_idx);
        end
      end
      default: w_state_next = S_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BLANK;
      r_shadow     <= '0;
      r_hex        <= 4'h0;
      r_dign       <= DIGIT_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shadow     <= w_shadow_next;
      r_hex        <= w_hex_next;
      r_dign       <= w_dign_next;
      r_frame_done <= w_fd_next;
    end
  end

  assign hex_out    = r_hex;
  assign dign       = r_dign;
  assign frame_done = r_frame_done;

endmodule
